byte_serializer: RTL and testbench

- Parallel-to-serial transmitter. Accepts an 8-bit word over a valid/ready handshake and shifts it out one bit per accepted beat.
- Serves as the send side for our parallel DFF register banks. A parallel byte goes in here and leaves as a framed bit stream for a downstream serial-to-parallel capture stage.
- Supports backpressure on the serial side and back-to-back words with no idle bubble.

---
 rtl/byte_serializer_if.sv | 23 ++
 rtl/byte_serializer.sv | 89 ++++++++
 tb/tb_byte_serializer.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/byte_serializer_if.sv
// Handshake bundle for byte_serializer: parallel word input plus the framed serial output stream.
// The slave modport is the serializer's view; the master modport is the producer/consumer side.
interface byte_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             ser_out;
  logic             ser_valid;
  logic             ser_last;
  logic             ser_ready;

  modport slave (
    input  in_data, in_valid, ser_ready,
    output in_ready, ser_out, ser_valid, ser_last
  );

  modport master (
    output in_data, in_valid, ser_ready,
    input  in_ready, ser_out, ser_valid, ser_last
  );
endinterface

// File: rtl/byte_serializer.sv
// Parallel-to-serial transmitter: takes a WIDTH-bit word on a valid/ready handshake and emits it
// one bit per accepted beat, with ser_last framing and back-to-back reload on the final beat.
module byte_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  byte_serializer_if.slave  bus
);
  localparam int CW   = $clog2(WIDTH);
  localparam int HEAD = MSB_FIRST ? WIDTH - 1 : 0;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] shift_next;
  logic [CW-1:0]    cnt_reg;
  logic             ser_out_reg;
  logic             ser_valid_reg;
  logic             ser_last_reg;
  logic             in_ready_int;
  logic             accept;
  logic             beat;

  // Reload is allowed on the final beat so consecutive words leave no idle gap.
  assign in_ready_int = (state_reg == IDLE) ||
                        ((state_reg == SHIFT) && ser_last_reg && bus.ser_ready);
  assign accept       = bus.in_valid && in_ready_int;
  assign beat         = ser_valid_reg && bus.ser_ready;

  assign bus.in_ready  = in_ready_int;
  assign bus.ser_out   = ser_out_reg;
  assign bus.ser_valid = ser_valid_reg;
  assign bus.ser_last  = ser_last_reg;

  // Shift one position toward the output end, filling with zero.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shift
      if (MSB_FIRST) begin : g_msb
        if (gi == 0) begin : g_fill
          assign shift_next[gi] = 1'b0;
        end else begin : g_move
          assign shift_next[gi] = shift_reg[gi-1];
        end
      end else begin : g_lsb
        if (gi == WIDTH - 1) begin : g_fill
          assign shift_next[gi] = 1'b0;
        end else begin : g_move
          assign shift_next[gi] = shift_reg[gi+1];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      shift_reg     <= '0;
      cnt_reg       <= '0;
      ser_out_reg   <= 1'b0;
      ser_valid_reg <= 1'b0;
      ser_last_reg  <= 1'b0;
    end else if (accept) begin
      state_reg     <= SHIFT;
      shift_reg     <= bus.in_data;
      cnt_reg       <= '0;
      ser_out_reg   <= bus.in_data[HEAD];
      ser_valid_reg <= 1'b1;
      ser_last_reg  <= 1'b0;
    end else if (beat) begin
      if (ser_last_reg) begin
        state_reg     <= IDLE;
        shift_reg     <= '0;
        cnt_reg       <= '0;
        ser_out_reg   <= 1'b0;
        ser_valid_reg <= 1'b0;
        ser_last_reg  <= 1'b0;
      end else begin
        shift_reg     <= shift_next;
        cnt_reg       <= cnt_reg + CW'(1);
        ser_out_reg   <= shift_next[HEAD];
        // Next beat is the last one once the counter is about to reach WIDTH-1.
        ser_last_reg  <= (cnt_reg == CW'(WIDTH - 2));
      end
    end
  end
endmodule

// File: tb/tb_byte_serializer.sv
// Directed bench: an MSB-first and an LSB-first serializer driven with identical stimulus,
// checked against hand-computed bit sequences.
module tb_byte_serializer;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  byte_serializer_if #(.WIDTH(8)) if_msb ();
  byte_serializer_if #(.WIDTH(8)) if_lsb ();

  byte_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_msb.slave)
  );

  byte_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_lsb.slave)
  );

  typedef struct {
    logic [7:0] data;
    logic [7:0] exp_msb;  // transmit order, first bit at [7]
    logic [7:0] exp_lsb;
  } vec_t;

  vec_t vecs [4];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] d, input logic v, input logic r);
    if_msb.in_data   = d;
    if_msb.in_valid  = v;
    if_msb.ser_ready = r;
    if_lsb.in_data   = d;
    if_lsb.in_valid  = v;
    if_lsb.ser_ready = r;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_beat(input string tag, input logic om, input logic ol,
                          input logic last, input logic rdy);
    chk({tag, " msb valid"}, 16'(if_msb.ser_valid), 16'd1);
    chk({tag, " msb out"},   16'(if_msb.ser_out),   16'(om));
    chk({tag, " msb last"},  16'(if_msb.ser_last),  16'(last));
    chk({tag, " msb ready"}, 16'(if_msb.in_ready),  16'(rdy));
    chk({tag, " lsb valid"}, 16'(if_lsb.ser_valid), 16'd1);
    chk({tag, " lsb out"},   16'(if_lsb.ser_out),   16'(ol));
    chk({tag, " lsb last"},  16'(if_lsb.ser_last),  16'(last));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " msb valid"}, 16'(if_msb.ser_valid), 16'd0);
    chk({tag, " msb last"},  16'(if_msb.ser_last),  16'd0);
    chk({tag, " msb ready"}, 16'(if_msb.in_ready),  16'd1);
    chk({tag, " lsb valid"}, 16'(if_lsb.ser_valid), 16'd0);
    chk({tag, " lsb ready"}, 16'(if_lsb.in_ready),  16'd1);
  endtask

  initial begin
    logic [15:0] b2b_m;
    logic [15:0] b2b_l;
    logic [10:0] rdy_pat;
    logic [10:0] out_pat;
    logic [7:0]  em;
    logic [7:0]  el;

    vecs[0] = '{data: 8'hAA, exp_msb: 8'b10101010, exp_lsb: 8'b01010101};
    vecs[1] = '{data: 8'hC3, exp_msb: 8'b11000011, exp_lsb: 8'b11000011};
    vecs[2] = '{data: 8'h01, exp_msb: 8'b00000001, exp_lsb: 8'b10000000};
    vecs[3] = '{data: 8'h80, exp_msb: 8'b10000000, exp_lsb: 8'b00000001};

    // Reset held with random inputs
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(8'($urandom), 1'($urandom), 1'($urandom));
      step();
      chk_idle("reset");
      chk("reset msb out", 16'(if_msb.ser_out), 16'd0);
    end
    drive(8'h00, 1'b0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_idle("idle");
    end

    // Table-driven single words, with in_data scrambled while busy
    for (int v = 0; v < 4; v++) begin
      drive(vecs[v].data, 1'b1, 1'b1);
      step();
      for (int b = 0; b < 8; b++) begin
        drive(~vecs[v].data ^ 8'(b), (b != 7), 1'b1);
        em = vecs[v].exp_msb;
        el = vecs[v].exp_lsb;
        chk_beat($sformatf("vec%0d beat%0d", v, b), em[7-b], el[7-b], (b == 7), (b == 7));
        step();
      end
      chk_idle($sformatf("vec%0d after", v));
      $display("word %02h: msb-first and lsb-first frames checked", vecs[v].data);
    end

    // Back-to-back AA then 55 with in_valid held high
    b2b_m = 16'b1010101001010101;
    b2b_l = 16'b0101010110101010;
    drive(8'hAA, 1'b1, 1'b1);
    step();
    drive(8'h55, 1'b1, 1'b1);
    for (int b = 0; b < 16; b++) begin
      if (b == 8) drive(8'hFF, 1'b0, 1'b1);
      chk_beat($sformatf("b2b beat%0d", b), b2b_m[15-b], b2b_l[15-b],
               (b == 7 || b == 15), (b == 7 || b == 15));
      step();
    end
    chk_idle("b2b after");
    $display("words aa,55 back-to-back: 16 contiguous beats checked");

    // Backpressure on C3: three stalled cycles on the fourth beat
    rdy_pat = 11'b11100011111;
    out_pat = 11'b11000000011;
    drive(8'hC3, 1'b1, 1'b1);
    step();
    for (int c = 0; c < 11; c++) begin
      drive(8'h3C, 1'b0, rdy_pat[10-c]);
      #1;
      chk_beat($sformatf("bp cycle%0d", c), out_pat[10-c], out_pat[10-c],
               (c == 10), (c == 10));
      step();
    end
    drive(8'h00, 1'b0, 1'b1);
    chk_idle("bp after");
    $display("word c3 with backpressure: 11 cycles checked");

    // Reset between edges during beat 4 of F0
    drive(8'hF0, 1'b1, 1'b1);
    step();
    drive(8'h00, 1'b0, 1'b1);
    for (int b = 0; b < 3; b++) step();
    chk_beat("pre-reset beat3", 1'b1, 1'b0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle("async reset");
    chk("async reset msb out", 16'(if_msb.ser_out), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk_idle("no resume");
    drive(8'h0F, 1'b1, 1'b1);
    step();
    drive(8'h00, 1'b0, 1'b1);
    em = 8'b00001111;
    el = 8'b11110000;
    for (int b = 0; b < 8; b++) begin
      chk_beat($sformatf("post-reset beat%0d", b), em[7-b], el[7-b], (b == 7), (b == 7));
      step();
    end
    chk_idle("post-reset after");
    $display("word f0 aborted by reset, word 0f sent afterwards");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
